// File: rtl/io_uart_rx_mon.sv
// Multi-channel 8N1 UART receive monitor: decodes each input pin, flags bad stop
// bits and checks every stream against an incrementing byte sequence from 0x00.
module io_uart_rx_mon #(
    parameter int unsigned IO_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  baud_load,
    input  logic [31:0]           baud_div,
    input  logic [IO_WIDTH-1:0]   io_i,
    output logic [8*IO_WIDTH-1:0] rx_data,
    output logic [IO_WIDTH-1:0]   rx_valid,
    output logic [IO_WIDTH-1:0]   frame_err,
    output logic [IO_WIDTH-1:0]   seq_err,
    output logic [IO_WIDTH-1:0]   busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic [31:0]         div_r;
    logic [IO_WIDTH-1:0] sync_q;
    logic [IO_WIDTH-1:0] s;
    logic [IO_WIDTH-1:0] s_d;
    logic                en_d;
    logic                en_rise;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
            s      <= '1;
            s_d    <= '1;
        end else begin
            sync_q <= io_i;
            s      <= sync_q;
            s_d    <= s;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_r <= 32'd868;
            en_d  <= 1'b0;
        end else begin
            en_d <= en;
            if (baud_load) begin
                div_r <= (baud_div < 32'd4) ? 32'd4 : baud_div;
            end
        end
    end

    assign en_rise = en & ~en_d;

    for (genvar g = 0; g < IO_WIDTH; g++) begin : g_ch
        state_t      state;
        state_t      state_nx;
        logic [31:0] div_c;
        logic [31:0] timer;
        logic [2:0]  idx;
        logic [7:0]  shreg;
        logic [7:0]  exp_b;
        logic [7:0]  data_q;
        logic        valid_q;
        logic        ferr_q;
        logic        serr_q;
        logic        expired;
        logic        load_start;
        logic        load_bit;
        logic        do_shift;
        logic        done_ok;
        logic        done_bad;
        logic        busy_c;

        assign expired = (timer == 32'd1);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                state <= IDLE;
            end else begin
                state <= state_nx;
            end
        end

        always_comb begin
            state_nx = state;
            if (!en) begin
                state_nx = IDLE;
            end else begin
                unique case (state)
                    IDLE:      if (s_d[g] && !s[g]) state_nx = START;
                    START:     if (expired) state_nx = s[g] ? IDLE : DATA;
                    DATA:      if (expired && idx == 3'd7) state_nx = STOP;
                    STOP:      if (expired) state_nx = s[g] ? IDLE : WAIT_HIGH;
                    WAIT_HIGH: if (s[g]) state_nx = IDLE;
                    default:   state_nx = IDLE;
                endcase
            end
        end

        always_comb begin
            load_start = en && state == IDLE && s_d[g] && !s[g];
            load_bit   = en && expired && ((state == START && !s[g]) || state == DATA);
            do_shift   = en && expired && state == DATA;
            done_ok    = en && expired && state == STOP && s[g];
            done_bad   = en && expired && state == STOP && !s[g];
            busy_c     = state != IDLE;
        end

        // div_c is captured on the same edge, so the half-bit wait is taken from div_r
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                div_c   <= 32'd868;
                timer   <= '0;
                idx     <= '0;
                shreg   <= '0;
                exp_b   <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
                ferr_q  <= 1'b0;
                serr_q  <= 1'b0;
            end else begin
                valid_q <= done_ok;
                if (load_start) begin
                    div_c <= div_r;
                    timer <= div_r >> 1;
                    idx   <= '0;
                end else if (load_bit) begin
                    timer <= div_c;
                end else if (timer != 32'd0) begin
                    timer <= timer - 32'd1;
                end
                if (do_shift) begin
                    shreg <= {s[g], shreg[7:1]};
                    idx   <= idx + 3'd1;
                end
                if (en_rise) begin
                    exp_b  <= '0;
                    ferr_q <= 1'b0;
                    serr_q <= 1'b0;
                end else begin
                    if (done_ok) begin
                        data_q <= shreg;
                        exp_b  <= shreg + 8'd1;
                        if (shreg != exp_b) serr_q <= 1'b1;
                    end
                    if (done_bad) ferr_q <= 1'b1;
                end
            end
        end

        assign rx_data[8*g +: 8] = data_q;
        assign rx_valid[g]       = valid_q;
        assign frame_err[g]      = ferr_q;
        assign seq_err[g]        = serr_q;
        assign busy[g]           = busy_c;
    end
endmodule

// File: tb/tb_io_uart_rx_mon.sv
// Scoreboard bench for io_uart_rx_mon: frames are queued with their expected byte,
// sticky flags and arrival cycle; a monitor pops and compares on every rx_valid.
module tb_io_uart_rx_mon;
    localparam int unsigned W = 2;

    logic           clk = 1'b0;
    logic           rstn;
    logic           en;
    logic           baud_load;
    logic [31:0]    baud_div;
    logic [W-1:0]   io;
    logic [8*W-1:0] rx_data;
    logic [W-1:0]   rx_valid;
    logic [W-1:0]   frame_err;
    logic [W-1:0]   seq_err;
    logic [W-1:0]   busy;

    io_uart_rx_mon #(.IO_WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .baud_load (baud_load),
        .baud_div  (baud_div),
        .io_i      (io),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .seq_err   (seq_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       serr;
        logic       ferr;
        longint     due;
    } exp_t;

    exp_t         q[W][$];
    logic [7:0]   exp_m[W];
    logic [7:0]   last_m[W];
    logic [W-1:0] serr_m;
    logic [W-1:0] ferr_m;
    int unsigned  div_m;

    task automatic check(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            exp_m[i] = 8'h00;
            last_m[i] = 8'h00;
            q[i].delete();
        end
        serr_m = '0;
        ferr_m = '0;
        div_m = 868;
    endtask

    task automatic model_en_rise();
        for (int i = 0; i < W; i++) exp_m[i] = 8'h00;
        serr_m = '0;
        ferr_m = '0;
    endtask

    task automatic load_baud(input logic [31:0] v);
        baud_div = v;
        baud_load = 1'b1;
        @(posedge clk);
        #1;
        baud_load = 1'b0;
        div_m = (v < 4) ? 4 : v;
    endtask

    task automatic drain();
        repeat (2 * div_m + 20) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_seq_err"}, seq_err, serr_m);
        check({tag, "_frame_err"}, frame_err, ferr_m);
    endtask

    // Called at posedge+1; the start bit enters the pin this cycle.
    task automatic send_frame(input logic [W-1:0] mask, input logic [7:0] b0, input logic [7:0] b1,
                              input bit stop_ok, input int unsigned dv, input bit gap);
        logic [7:0] bt[W];
        logic [9:0] fr[W];
        exp_t e;
        bt[0] = b0;
        bt[1] = b1;
        for (int i = 0; i < W; i++) begin
            fr[i] = {stop_ok, bt[i], 1'b0};
            if (mask[i]) begin
                if (stop_ok) begin
                    serr_m[i] = serr_m[i] | (bt[i] != exp_m[i]);
                    exp_m[i] = bt[i] + 8'd1;
                    last_m[i] = bt[i];
                    e.data = bt[i];
                    e.serr = serr_m[i];
                    e.ferr = ferr_m[i];
                    e.due = cyc + 3 + longint'(dv / 2) + 9 * longint'(dv);
                    q[i].push_back(e);
                end else begin
                    ferr_m[i] = 1'b1;
                end
            end
        end
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < W; i++) if (mask[i]) io[i] = fr[i][b];
            repeat (dv) @(posedge clk);
            #1;
        end
        if (gap) begin
            repeat (dv) @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int i = 0; i < W; i++) begin
                if (rx_valid[i] === 1'b1) begin
                    if (q[i].size() == 0) begin
                        check($sformatf("spurious_valid_ch%0d", i), rx_valid[i], 0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        check($sformatf("rx_data_ch%0d", i), rx_data[8*i +: 8], e.data);
                        check($sformatf("seq_err_ch%0d", i), seq_err[i], e.serr);
                        check($sformatf("frame_err_ch%0d", i), frame_err[i], e.ferr);
                        check($sformatf("valid_cycle_ch%0d", i), cyc, e.due);
                    end
                end
            end
        end
    end

    logic [W-1:0] m;
    logic [7:0]   r0;
    logic [7:0]   r1;
    longint       t_start;

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        baud_load = 1'b0;
        baud_div = '0;
        io = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_flags", {frame_err, seq_err}, 0);
        check("reset_busy", busy, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        load_baud(16);
        en = 1'b1;
        model_en_rise();
        @(posedge clk);
        #1;

        // basic sequence on ch0
        for (int b = 0; b < 3; b++) send_frame(2'b01, 8'(b), 8'h00, 1'b1, div_m, 1'b1);
        drain();
        check_flags("basic");

        // mismatch and resync on ch1
        send_frame(2'b10, 8'h00, 8'h00, 1'b1, div_m, 1'b1);
        send_frame(2'b10, 8'h00, 8'h05, 1'b1, div_m, 1'b1);
        send_frame(2'b10, 8'h00, 8'h06, 1'b1, div_m, 1'b1);
        drain();
        check_flags("mismatch");

        // framing error: low stop bit held, then released
        send_frame(2'b01, 8'h00, 8'h00, 1'b0, div_m, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("ferr_busy_held", busy[0], 1);
        check("ferr_flag", frame_err[0], 1);
        check("ferr_rx_data_kept", rx_data, {last_m[1], last_m[0]});
        io[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("ferr_busy_released", busy[0], 0);
        send_frame(2'b01, 8'h00, 8'h00, 1'b1, div_m, 1'b1);
        drain();
        check_flags("after_ferr");

        // glitch: 4-cycle low pulse
        io[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("glitch_busy_before_t0", busy[0], 0);
        @(posedge clk);
        #1;
        check("glitch_busy_t0p1", busy[0], 1);
        @(posedge clk);
        #1;
        io[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("glitch_busy_low", busy[0], 0);
        drain();
        check_flags("glitch");

        // drop en mid-frame, then re-raise
        io[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("en_busy_midframe", busy[0], 1);
        en = 1'b0;
        io[0] = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("en_off_busy", busy, 0);
        check_flags("en_off_hold");
        en = 1'b1;
        model_en_rise();
        repeat (2) @(posedge clk);
        #1;
        check_flags("en_rise_clear");
        send_frame(2'b01, 8'h00, 8'h00, 1'b1, div_m, 1'b1);
        drain();
        check_flags("en_exp_zero");

        // baud load mid-frame only affects the next frame
        fork
            send_frame(2'b01, exp_m[0], 8'h00, 1'b1, 16, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1;
                load_baud(32);
            end
        join
        send_frame(2'b01, exp_m[0], 8'h00, 1'b1, div_m, 1'b1);
        drain();
        check_flags("baud_change");

        // asynchronous reset mid-frame
        io = '0;
        repeat (30) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_rx_data", rx_data, 0);
        check("areset_valid_flags", {rx_valid, frame_err, seq_err}, 0);
        model_reset();
        io = '1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // clamped divisor, back-to-back prime then wrap on both channels
        load_baud(2);
        for (int v = 0; v < 254; v++) send_frame(2'b11, 8'(v), 8'(v), 1'b1, div_m, 1'b0);
        t_start = cyc;
        send_frame(2'b11, 8'hFE, 8'hFE, 1'b1, div_m, 1'b0);
        send_frame(2'b11, 8'hFF, 8'hFF, 1'b1, div_m, 1'b0);
        send_frame(2'b11, 8'h00, 8'h00, 1'b1, div_m, 1'b0);
        drain();
        check_flags("wrap");
        check("wrap_rx_data", rx_data, 16'h0000);

        // randomized traffic
        for (int grp = 0; grp < 5; grp++) begin
            load_baud($urandom_range(0, 20));
            for (int k = 0; k < 8; k++) begin
                m = W'($urandom_range(1, 3));
                r0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_m[0];
                r1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : exp_m[1];
                send_frame(m, r0, r1, 1'b1, div_m, 1'($urandom_range(0, 1)));
            end
            drain();
            check_flags("random");
        end

        for (int i = 0; i < W; i++) check($sformatf("pending_frames_ch%0d", i), q[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/io_uart_rx_mon.md
# io_uart_rx_mon

Multi-channel UART receive monitor for the IO test path. Each of `IO_WIDTH` input pins carries an independent 8N1 UART stream. The block decodes every frame, reports framing errors, and checks each stream against an incrementing byte sequence starting at 0x00. It is the receiving end of the IO UART test: it sits on the input IOs, opposite the block that drives test frames onto the output IOs, and shares that block's baud-divider load convention.

## Interface
- `IO_WIDTH`, default 2: number of monitored input channels.
- `clk`, input, 1: system clock (100 MHz).
- `rstn`, input, 1: asynchronous active-low reset.
- `en`, input, 1: channel enable; a rising edge restarts the sequence check.
- `baud_load`, input, 1: one-cycle strobe that captures `baud_div`.
- `baud_div`, input, 32: clocks per UART bit.
- `io_i`, input, IO_WIDTH: asynchronous UART input pins.
- `rx_data`, output, 8*IO_WIDTH: last good byte per channel; channel n is at [8n+7:8n].
- `rx_valid`, output, IO_WIDTH: one-cycle pulse per channel when `rx_data` updates.
- `frame_err`, output, IO_WIDTH: sticky flag, set on a bad stop bit.
- `seq_err`, output, IO_WIDTH: sticky flag, set on a sequence mismatch.
- `busy`, output, IO_WIDTH: high while the channel is inside a frame.

## Operation
- **Divisor**
  - `div_r` (32 b) resets to 868.
  - On `baud_load`, `div_r <= max(baud_div, 4)`.
  - Each channel copies `div_r` into its own `div_c` when a start bit is detected. A load during a frame does not affect that frame.
  - `half = div_c >> 1`.
- **Input synchronizer:** each `io_i` bit passes through a 2-flop synchronizer with reset value 1, giving `s`. A third flop holds `s_d` for edge detection.
- **Per-channel FSM:** states IDLE, START, DATA, STOP, WAIT_HIGH, with a 32-bit bit timer and a 3-bit bit index.
  - IDLE: if `en` and `s_d`=1 and `s`=0, go to START, load `div_c`, and set timer = `half`.
  - START: when the timer expires, sample `s`.
    - `s`=1 is a glitch: go to IDLE with no flags set.
    - `s`=0: go to DATA with index 0 and timer = `div_c`.
  - DATA: at each expiry, shift `s` in LSB-first. After bit 7, go to STOP with timer = `div_c`.
  - STOP: at expiry, sample `s`.
    - `s`=1: go to IDLE. Next cycle, `rx_valid` pulses and `rx_data` updates.
    - `s`=0: set `frame_err`, leave `rx_data` unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE when `s`=1.
- **`busy`:** high in START, DATA, STOP and WAIT_HIGH.
- **Enable**
  - `en`=0 forces every channel to IDLE on the next clock. A partial frame produces no `rx_valid` and no flag.
  - Sticky flags and `rx_data` hold their values while `en`=0.
- **Sequence check**
  - Each channel keeps `exp` (8 b).
  - On a valid byte: if `byte != exp`, set `seq_err`. In both cases, `exp <= byte + 1` (mod 256), so the check resynchronises after a mismatch.
  - Wrap: 0xFF is followed by an expected 0x00.
- **`en` rising edge** (registered `en` compare): `exp <= 0`, `frame_err <= 0`, `seq_err <= 0`, in the same cycle for all channels.
- **Independence:** channels are fully independent; simultaneous frames on all channels are legal.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `seq_err` = 0, `busy` = 0.
  - Synchronizer flops = 1, `div_r` = 868, `exp` = 0, FSM = IDLE.
- Pin to `s` latency: 2 cycles.
- Let t0 be the first cycle with `s`=0 and `s_d`=1. Sample points:
  - Start bit at t0 + `half`.
  - Data bit k at t0 + `half` + (k+1)·`div_c`.
  - Stop bit at t0 + `half` + 9·`div_c`.
- `rx_valid`, `rx_data` and `seq_err` update at t0 + `half` + 9·`div_c` + 1.
- `frame_err` sets at the stop-bit sample cycle + 1.
- `busy` rises at t0 + 1. It falls with the `rx_valid` cycle, or one cycle after `s` returns high in WAIT_HIGH.
- A new start bit is accepted from the first IDLE cycle. Back-to-back frames with a one-bit stop are decoded without loss.
- Reset asserted mid-frame aborts immediately and asynchronously: all outputs return to reset values with no pulse.

## Test plan
- **Basic sequence:** reset, load `baud_div`=16, `en`=1. Send 0x00, 0x01, 0x02 on ch0. Expect three `rx_valid[0]` pulses with data 0x00/0x01/0x02, `seq_err`=0, `frame_err`=0, and each pulse exactly `half`+9·16+1 = 153 cycles after t0.
- **Mismatch and resync:** send 0x00, 0x05, 0x06 on ch1. Expect `seq_err[1]` to set on 0x05 and stay set, no further error on 0x06, and ch0 flags unaffected.
- **Framing error:** send 0x00 with a low stop bit, hold low 40 cycles, then release. Expect `frame_err[0]`=1, no `rx_valid`, `rx_data` unchanged and `busy` high until the line goes high. A following 0x00 decodes normally.
- **Glitch rejection:** low pulse of 4 cycles at `div`=16. Expect no `rx_valid`, no flags, and `busy` low again 8 cycles after t0.
- **Enable and baud control:**
  - Drop `en` mid-frame: no `rx_valid`; flags retained.
  - Re-raise `en`: `frame_err`/`seq_err` clear and `exp`=0.
  - Pulse `baud_load` mid-frame with 32: the frame still decodes at 16; the next frame decodes at 32.
- **Parallel and wrap:** send 0xFE, 0xFF, 0x00 on both channels simultaneously. Expect both channels valid in the same cycles with `seq_err`=0 (after priming `exp`=0xFE via a leading 0x00..0xFD run, or by accepting the first mismatch and then checking that the wrap raises no new error).
